mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Sequences the single shared RAM port between the instruction-fetch requester and the data load/store requester of the MIPS core. Data access has priority, with a bounded-starvation guarantee for fetch. The block holds a grant until RAM reports ACCESS and returns one-cycle hit pulses to the winner. It also detects RAM errors and RAM timeouts.

Parameters:
MAX_DSTREAK, 4, consecutive data grants allowed while iREN is pending before fetch is forced to win.
TIMEOUT, 64, cycles a grant may wait for ACCESS before entering ERR.
ADDR_W, 32, address and data width.

Ports:
CLK  in  1  clock; all state updates on rising edge.
nRST  in  1  asynchronous active-low reset.
iREN  in  1  fetch request; held until ihit.
iaddr  in  ADDR_W  fetch address.
dREN  in  1  data read request; held until dhit.
dWEN  in  1  data write request; held until dhit.
daddr  in  ADDR_W  data address.
dstore  in  ADDR_W  write data.
ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.
ramload  in  ADDR_W  RAM read data.
clr_err  in  1  leave ERR state.
ramREN  out  1  RAM read strobe.
ramWEN  out  1  RAM write strobe.
ramaddr  out  ADDR_W  RAM address.
ramstore  out  ADDR_W  RAM write data.
ihit  out  1  fetch complete pulse.
dhit  out  1  data complete pulse.
iload  out  ADDR_W  fetch data, valid when ihit.
dload  out  ADDR_W  load data, valid when dhit.
err  out  1  high while in ERR.

Behaviour:
- States: IDLE, IGRANT, DGRANT, ERR. Reset puts the FSM in IDLE, sets dstreak=0 and tcnt=0.
- Reset values: all outputs 0; ramaddr and ramstore are also 0.
- IDLE arbitration:
  - If (dREN|dWEN) and not (iREN and dstreak==MAX_DSTREAK), go to DGRANT.
  - Else if iREN, go to IGRANT.
  - Else stay in IDLE.
- dstreak updates, applied on the arbitration edge:
  - DGRANT taken with iREN=1: dstreak+1, saturating at MAX_DSTREAK.
  - DGRANT taken with iREN=0: dstreak=0.
  - IGRANT taken: dstreak=0.
- RAM drive is combinational from state:
  - IGRANT: ramREN=1, ramaddr=iaddr.
  - DGRANT: ramaddr=daddr, ramstore=dstore. ramWEN=dWEN; ramREN=dREN&~dWEN. If both dREN and dWEN are high, the access is a write.
  - IDLE and ERR: strobes 0, ramaddr=0, ramstore=0.
- Hit and load outputs:
  - ihit = (IGRANT & ramstate==ACCESS); dhit = (DGRANT & ramstate==ACCESS). Both are combinational single-cycle pulses.
  - iload=ramload when ihit, else 0. dload=ramload when dhit, else 0.
- Grant exit paths:
  - ACCESS: next state IDLE. One mandatory bubble cycle follows before the next grant.
  - Requester drops its request while granted (IGRANT with iREN=0, or DGRANT with dREN=dWEN=0): abort. Next state is IDLE, no hit, and the abort does not count as a grant.
  - ramstate==ERROR, or tcnt reaches TIMEOUT-1 without ACCESS: next state ERR. ERROR takes precedence over abort.
- Latency: a request first seen in IDLE at cycle 0 drives the RAM from cycle 1. The earliest hit is in cycle 1, when RAM returns ACCESS immediately.
- tcnt: cleared on every grant entry; increments each grant cycle without ACCESS; width ceil(log2(TIMEOUT))+1.
- ERR:
  - err=1 and no grants are issued.
  - clr_err=1 returns to IDLE on the next edge with dstreak=0.
  - Requests arriving during ERR are ignored and are not queued.
- Reset mid-grant: strobes drop immediately (asynchronous), no hit is produced, and the requester must re-present the request.

Test Plan:
- Fetch only: iREN=1, iaddr=0x40, RAM gives ACCESS on 2nd grant cycle with ramload=0x8C220004 -> ramREN high from cycle 1, ihit=1 and iload=0x8C220004 in cycle 2, IDLE in cycle 3.
- Simultaneous: iREN=1, dWEN=1, daddr=0x100, dstore=0xDEADBEEF -> DGRANT first, ramWEN=1, ramstore=0xDEADBEEF. After dhit, the bubble, then IGRANT.
- Starvation: iREN and dREN both held with RAM always ACCESS -> exactly 4 dhits, then an ihit, and the pattern repeats.
- Timeout: dREN=1 with ramstate held BUSY -> err=1 after 64 grant cycles with no dhit. clr_err=1 -> IDLE next cycle, err=0.
- Abort and reset: iREN dropped in IGRANT -> IDLE next cycle, no ihit. nRST=0 during DGRANT -> ramWEN/ramREN=0 immediately, all outputs 0.
- Both dREN=dWEN=1 -> ramWEN=1, ramREN=0.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the MIPS core requesters, the shared RAM port and the arbiter.
// The arbiter uses the slave modport; the environment around it uses master.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    logic [ADDR_W-1:0] dstore;
    logic [1:0]        ramstate;
    logic [ADDR_W-1:0] ramload;
    logic              clr_err;
    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [ADDR_W-1:0] ramstore;
    logic              ihit;
    logic              dhit;
    logic [ADDR_W-1:0] iload;
    logic [ADDR_W-1:0] dload;
    logic              err;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload, clr_err,
        output ramREN, ramWEN, ramaddr, ramstore, ihit, dhit, iload, dload, err
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload, clr_err,
        input  ramREN, ramWEN, ramaddr, ramstore, ihit, dhit, iload, dload, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one RAM port between instruction fetch and data load/store, giving data
// priority while guaranteeing fetch a grant after MAX_DSTREAK back-to-back data grants.
module mem_arbiter #(
    parameter int MAX_DSTREAK = 4,
    parameter int TIMEOUT     = 64,
    parameter int ADDR_W      = 32
) (
    input logic          CLK,
    input logic          nRST,
    mem_arbiter_if.slave bus
);
    localparam int DS_W = $clog2(MAX_DSTREAK + 1);
    localparam int TC_W = $clog2(TIMEOUT) + 1;
    localparam logic [DS_W-1:0] DS_MAX   = DS_W'(MAX_DSTREAK);
    localparam logic [TC_W-1:0] TC_LAST  = TC_W'(TIMEOUT - 1);
    localparam logic [1:0]      RS_ACCESS = 2'd2;
    localparam logic [1:0]      RS_ERROR  = 2'd3;

    typedef enum logic [1:0] {IDLE, IGRANT, DGRANT, ERR} state_t;

    state_t            r_state;
    logic [DS_W-1:0]   r_dstreak;
    logic [TC_W-1:0]   r_tcnt;

    logic              w_dreq;
    logic              w_grantReq;
    logic              w_access;
    logic              w_ihit;
    logic              w_dhit;
    logic [ADDR_W-1:0] w_ramaddr;
    logic [ADDR_W-1:0] w_ramstore;

    assign w_dreq     = bus.dREN | bus.dWEN;
    assign w_access   = (bus.ramstate == RS_ACCESS);
    assign w_grantReq = (r_state == IGRANT) ? bus.iREN : w_dreq;

    // A grant always falls back to IDLE, so every access is followed by one bubble cycle.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state   <= IDLE;
            r_dstreak <= '0;
            r_tcnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_dreq && !(bus.iREN && r_dstreak == DS_MAX)) begin
                        r_state   <= DGRANT;
                        r_tcnt    <= '0;
                        r_dstreak <= bus.iREN ? r_dstreak + DS_W'(1) : '0;
                    end else if (bus.iREN) begin
                        r_state   <= IGRANT;
                        r_tcnt    <= '0;
                        r_dstreak <= '0;
                    end
                end
                IGRANT, DGRANT: begin
                    if (bus.ramstate == RS_ERROR) begin
                        r_state <= ERR;
                    end else if (w_access) begin
                        r_state <= IDLE;
                    end else if (r_tcnt == TC_LAST) begin
                        r_state <= ERR;
                    end else if (!w_grantReq) begin
                        r_state <= IDLE;
                    end else begin
                        r_tcnt <= r_tcnt + TC_W'(1);
                    end
                end
                ERR: begin
                    if (bus.clr_err) begin
                        r_state   <= IDLE;
                        r_dstreak <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // RAM drive follows the state directly so an asynchronous reset drops the strobes at once.
    always_comb begin
        w_ramaddr  = '0;
        w_ramstore = '0;
        case (r_state)
            IGRANT: w_ramaddr = bus.iaddr;
            DGRANT: begin
                w_ramaddr  = bus.daddr;
                w_ramstore = bus.dstore;
            end
            default: begin
                w_ramaddr  = '0;
                w_ramstore = '0;
            end
        endcase
    end

    assign w_ihit = (r_state == IGRANT) && w_access;
    assign w_dhit = (r_state == DGRANT) && w_access;

    assign bus.ramREN   = (r_state == IGRANT) || ((r_state == DGRANT) && bus.dREN && !bus.dWEN);
    assign bus.ramWEN   = (r_state == DGRANT) && bus.dWEN;
    assign bus.ramaddr  = w_ramaddr;
    assign bus.ramstore = w_ramstore;
    assign bus.ihit     = w_ihit;
    assign bus.dhit     = w_dhit;
    assign bus.iload    = w_ihit ? bus.ramload : '0;
    assign bus.dload    = w_dhit ? bus.ramload : '0;
    assign bus.err      = (r_state == ERR);
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change on the falling edge, outputs are
// checked 1ns later, so each check sees the state left by the preceding rising edge.
module tb_mem_arbiter;
    localparam int ADDR_W = 32;

    logic CLK = 1'b0;
    logic nRST;
    int   compared   = 0;
    int   mismatched = 0;

    mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    mem_arbiter #(.MAX_DSTREAK(4), .TIMEOUT(64), .ADDR_W(ADDR_W)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    task automatic clearInputs();
        bus.iREN = 1'b0; bus.iaddr = '0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
        bus.daddr = '0; bus.dstore = '0; bus.ramstate = 2'd0; bus.ramload = '0;
        bus.clr_err = 1'b0;
    endtask

    task automatic test_reset();
        logic [5*ADDR_W+4:0] outs;
        clearInputs();
        nRST = 1'b0;
        bus.iREN = 1'b1;
        bus.ramstate = 2'd2;
        #1;
        outs = {bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore, bus.ihit, bus.dhit, bus.iload, bus.dload, bus.err};
        compared++; if (outs !== '0) begin mismatched++; $display("[TB] FAIL reset_outputs: got %0h expected 0", outs); end
        repeat (2) @(negedge CLK);
        #1;
        compared++; if (bus.ramREN !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_hold_ramREN: got %b expected 0", bus.ramREN); end
        clearInputs();
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic test_fetch();
        @(negedge CLK);
        bus.iREN = 1'b1; bus.iaddr = 32'h40; bus.ramstate = 2'd0;
        #1;
        compared++; if (bus.ramREN !== 1'b0) begin mismatched++; $display("[TB] FAIL fetch_c0_ramREN: got %b expected 0", bus.ramREN); end
        @(negedge CLK);
        bus.ramstate = 2'd1;
        #1;
        compared++; if (bus.ramREN !== 1'b1) begin mismatched++; $display("[TB] FAIL fetch_c1_ramREN: got %b expected 1", bus.ramREN); end
        compared++; if (bus.ramaddr !== 32'h40) begin mismatched++; $display("[TB] FAIL fetch_c1_ramaddr: got %0h expected 40", bus.ramaddr); end
        compared++; if (bus.ihit !== 1'b0) begin mismatched++; $display("[TB] FAIL fetch_c1_ihit: got %b expected 0", bus.ihit); end
        @(negedge CLK);
        bus.ramstate = 2'd2; bus.ramload = 32'h8C220004;
        #1;
        compared++; if (bus.ihit !== 1'b1) begin mismatched++; $display("[TB] FAIL fetch_c2_ihit: got %b expected 1", bus.ihit); end
        compared++; if (bus.iload !== 32'h8C220004) begin mismatched++; $display("[TB] FAIL fetch_c2_iload: got %0h expected 8c220004", bus.iload); end
        @(negedge CLK);
        bus.iREN = 1'b0; bus.ramstate = 2'd0; bus.ramload = '0;
        #1;
        compared++; if ({bus.ramREN, bus.ihit} !== 2'b00) begin mismatched++; $display("[TB] FAIL fetch_c3_idle: got %b expected 00", {bus.ramREN, bus.ihit}); end
    endtask

    task automatic test_simultaneous();
        @(negedge CLK);
        bus.iREN = 1'b1; bus.iaddr = 32'h44;
        bus.dWEN = 1'b1; bus.daddr = 32'h100; bus.dstore = 32'hDEADBEEF;
        @(negedge CLK);
        bus.ramstate = 2'd2; bus.ramload = 32'h5555;
        #1;
        compared++; if ({bus.ramWEN, bus.ramREN} !== 2'b10) begin mismatched++; $display("[TB] FAIL simul_dgrant_strobes: got %b expected 10", {bus.ramWEN, bus.ramREN}); end
        compared++; if (bus.ramaddr !== 32'h100) begin mismatched++; $display("[TB] FAIL simul_ramaddr: got %0h expected 100", bus.ramaddr); end
        compared++; if (bus.ramstore !== 32'hDEADBEEF) begin mismatched++; $display("[TB] FAIL simul_ramstore: got %0h expected deadbeef", bus.ramstore); end
        compared++; if ({bus.dhit, bus.ihit} !== 2'b10) begin mismatched++; $display("[TB] FAIL simul_dhit: got %b expected 10", {bus.dhit, bus.ihit}); end
        compared++; if (bus.dload !== 32'h5555) begin mismatched++; $display("[TB] FAIL simul_dload: got %0h expected 5555", bus.dload); end
        @(negedge CLK);
        bus.dWEN = 1'b0; bus.ramstate = 2'd0;
        #1;
        compared++; if ({bus.ramWEN, bus.ramREN} !== 2'b00) begin mismatched++; $display("[TB] FAIL simul_bubble: got %b expected 00", {bus.ramWEN, bus.ramREN}); end
        @(negedge CLK);
        bus.ramstate = 2'd2; bus.ramload = 32'h77;
        #1;
        compared++; if (bus.ramaddr !== 32'h44) begin mismatched++; $display("[TB] FAIL simul_igrant_addr: got %0h expected 44", bus.ramaddr); end
        compared++; if (bus.ihit !== 1'b1) begin mismatched++; $display("[TB] FAIL simul_ihit: got %b expected 1", bus.ihit); end
        @(negedge CLK);
        clearInputs();
    endtask

    task automatic test_starvation();
        logic expI;
        logic expD;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (i == 0) begin
                bus.iREN = 1'b1; bus.iaddr = 32'h80; bus.dREN = 1'b1; bus.daddr = 32'h300;
                bus.ramstate = 2'd2; bus.ramload = 32'h0BADF00D;
            end
            #1;
            expI = (i == 9) || (i == 19);
            expD = (i % 2 == 1) && !expI;
            compared++; if (bus.ihit !== expI) begin mismatched++; $display("[TB] FAIL starve_ihit_c%0d: got %b expected %b", i, bus.ihit, expI); end
            compared++; if (bus.dhit !== expD) begin mismatched++; $display("[TB] FAIL starve_dhit_c%0d: got %b expected %b", i, bus.dhit, expD); end
            if (i == 1) begin
                compared++; if (bus.dload !== 32'h0BADF00D) begin mismatched++; $display("[TB] FAIL starve_dload: got %0h expected badf00d", bus.dload); end
            end
        end
        @(negedge CLK);
        clearInputs();
    endtask

    task automatic test_abort_error();
        @(negedge CLK);
        bus.iREN = 1'b1; bus.iaddr = 32'h90;
        @(negedge CLK);
        bus.iREN = 1'b0; bus.ramstate = 2'd1;
        #1;
        compared++; if ({bus.ramREN, bus.ihit} !== 2'b10) begin mismatched++; $display("[TB] FAIL abort_grant: got %b expected 10", {bus.ramREN, bus.ihit}); end
        @(negedge CLK);
        bus.ramstate = 2'd0;
        #1;
        compared++; if ({bus.ramREN, bus.ihit, bus.err} !== 3'b000) begin mismatched++; $display("[TB] FAIL abort_idle: got %b expected 000", {bus.ramREN, bus.ihit, bus.err}); end
        @(negedge CLK);
        bus.iREN = 1'b1;
        @(negedge CLK);
        bus.iREN = 1'b0; bus.ramstate = 2'd3;
        #1;
        compared++; if (bus.ihit !== 1'b0) begin mismatched++; $display("[TB] FAIL error_ihit: got %b expected 0", bus.ihit); end
        @(negedge CLK);
        bus.ramstate = 2'd0; bus.clr_err = 1'b1;
        #1;
        compared++; if ({bus.err, bus.ramREN} !== 2'b10) begin mismatched++; $display("[TB] FAIL error_over_abort: got %b expected 10", {bus.err, bus.ramREN}); end
        @(negedge CLK);
        bus.clr_err = 1'b0;
        #1;
        compared++; if (bus.err !== 1'b0) begin mismatched++; $display("[TB] FAIL error_clear: got %b expected 0", bus.err); end
    endtask

    task automatic test_timeout();
        int badCycles = 0;
        @(negedge CLK);
        bus.dREN = 1'b1; bus.daddr = 32'h400; bus.ramstate = 2'd1;
        for (int k = 1; k <= 64; k++) begin
            @(negedge CLK);
            #1;
            if (bus.dhit !== 1'b0 || bus.err !== 1'b0 || bus.ramREN !== 1'b1) badCycles++;
        end
        compared++; if (badCycles !== 0) begin mismatched++; $display("[TB] FAIL timeout_window: got %0d bad cycles expected 0", badCycles); end
        @(negedge CLK);
        #1;
        compared++; if ({bus.err, bus.ramREN, bus.dhit} !== 3'b100) begin mismatched++; $display("[TB] FAIL timeout_err: got %b expected 100", {bus.err, bus.ramREN, bus.dhit}); end
        bus.clr_err = 1'b1;
        @(negedge CLK);
        bus.clr_err = 1'b0; bus.dREN = 1'b0; bus.ramstate = 2'd0;
        #1;
        compared++; if ({bus.err, bus.ramREN} !== 2'b00) begin mismatched++; $display("[TB] FAIL timeout_clear: got %b expected 00", {bus.err, bus.ramREN}); end
        @(negedge CLK);
        #1;
        compared++; if (bus.ramREN !== 1'b0) begin mismatched++; $display("[TB] FAIL timeout_no_queue: got %b expected 0", bus.ramREN); end
    endtask

    task automatic test_reset_mid_grant();
        logic [2*ADDR_W+3:0] outs;
        @(negedge CLK);
        bus.dREN = 1'b1; bus.dWEN = 1'b1; bus.daddr = 32'h200; bus.dstore = 32'h12345678;
        @(negedge CLK);
        bus.ramstate = 2'd1;
        #1;
        compared++; if ({bus.ramWEN, bus.ramREN} !== 2'b10) begin mismatched++; $display("[TB] FAIL both_write: got %b expected 10", {bus.ramWEN, bus.ramREN}); end
        compared++; if (bus.ramstore !== 32'h12345678) begin mismatched++; $display("[TB] FAIL both_ramstore: got %0h expected 12345678", bus.ramstore); end
        nRST = 1'b0;
        bus.ramstate = 2'd2;
        #1;
        outs = {bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore, bus.dhit, bus.err};
        compared++; if (outs !== '0) begin mismatched++; $display("[TB] FAIL reset_mid_grant: got %0h expected 0", outs); end
        @(negedge CLK);
        nRST = 1'b1;
        clearInputs();
        @(negedge CLK);
        #1;
        compared++; if ({bus.ramWEN, bus.ramREN, bus.dhit} !== 3'b000) begin mismatched++; $display("[TB] FAIL reset_no_resume: got %b expected 000", {bus.ramWEN, bus.ramREN, bus.dhit}); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_simultaneous();
        test_starvation();
        test_abort_error();
        test_timeout();
        test_reset_mid_grant();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
